// File: rtl/column_projection.sv
// column_projection: vertical projection of a binary frame.
// Counts white pixels (bit 11 set) per column over one frame, then streams the
// per-column counts out over a valid/ready handshake.
// Projection memory is zeroed by the CLEAR sweep after reset or abort, and
// each entry is cleared again as it is read out.
// Optional feature: define ROW_PROJ_EN to add per-row white counts
// (row_valid / row_count).
module column_projection #(
   parameter int IMG_W = 640,
   parameter int IMG_H = 480,
   parameter int X_W   = 10,
   parameter int CNT_W = 9
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             frame_start,
   input  logic             pix_valid,
   input  logic             pix_last,
   input  logic [11:0]      pixel_binary,
   output logic             col_valid,
   input  logic             col_ready,
   output logic [X_W-1:0]   col_idx,
   output logic [CNT_W-1:0] col_count,
   output logic             col_last,
   output logic             busy,
   output logic             frame_done,
   output logic             overrun
`ifdef ROW_PROJ_EN
   ,
   output logic             row_valid,
   output logic [X_W:0]     row_count
`endif
);

   typedef enum logic [1:0] {
      ST_CLEAR   = 2'd0,
      ST_IDLE    = 2'd1,
      ST_ACCUM   = 2'd2,
      ST_READOUT = 2'd3
   } state_t;

   // x counts one past the last column so that over-long rows saturate
   localparam logic [X_W:0]     X_END_C  = (X_W+1)'(IMG_W);
   localparam logic [X_W-1:0]   X_LAST_C = X_W'(IMG_W-1);
   localparam logic [CNT_W-1:0] Y_LAST_C = CNT_W'(IMG_H-1);

   state_t           state_r;
   state_t           state_nxt_s;
   logic [CNT_W-1:0] mem_r [IMG_W];
   logic [X_W:0]     x_r;
   logic [CNT_W-1:0] y_r;
   logic [X_W-1:0]   clr_ptr_r;
   logic             start_pend_r;
   logic             col_valid_r;
   logic             col_last_r;
   logic [X_W-1:0]   col_idx_r;
   logic [CNT_W-1:0] col_count_r;
   logic             frame_done_r;
   logic             overrun_r;
   logic             busy_r;

   logic             pix_white_s;
   logic             x_in_range_s;
   logic             accept_pix_s;
   logic             frame_end_s;
   logic             xfer_s;
   logic             abort_s;
   logic             clr_done_s;
   logic [X_W-1:0]   nxt_idx_s;
   logic             mem_we_s;
   logic [X_W-1:0]   mem_addr_s;
   logic [CNT_W-1:0] mem_wdata_s;
   logic             unused_pix_s;

   // only bit 11 carries the binary decision
   assign pix_white_s  = pixel_binary[11];
   assign unused_pix_s = ^pixel_binary[10:0];
   assign x_in_range_s = (x_r < X_END_C);
   // a pixel sharing its cycle with frame_start is discarded
   assign accept_pix_s = (state_r == ST_ACCUM) && pix_valid && !frame_start;
   assign frame_end_s  = accept_pix_s && pix_last && (y_r == Y_LAST_C);
   assign xfer_s       = (state_r == ST_READOUT) && col_valid_r && col_ready && !frame_start;
   assign abort_s      = frame_start && ((state_r == ST_ACCUM) || (state_r == ST_READOUT));
   assign clr_done_s   = (state_r == ST_CLEAR) && (clr_ptr_r == X_LAST_C);
   assign nxt_idx_s    = col_idx_r + 1'b1;

   // state register
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_r <= ST_CLEAR;
      end else begin
         state_r <= state_nxt_s;
      end
   end

   // next-state decode
   always_comb begin
      state_nxt_s = state_r;
      case (state_r)
         ST_CLEAR: begin
            if (clr_done_s) begin
               if (start_pend_r || frame_start) begin
                  state_nxt_s = ST_ACCUM;
               end else begin
                  state_nxt_s = ST_IDLE;
               end
            end else begin
               state_nxt_s = ST_CLEAR;
            end
         end
         ST_IDLE: begin
            if (frame_start) begin
               state_nxt_s = ST_ACCUM;
            end else begin
               state_nxt_s = ST_IDLE;
            end
         end
         ST_ACCUM: begin
            if (frame_start) begin
               state_nxt_s = ST_CLEAR;
            end else if (frame_end_s) begin
               state_nxt_s = ST_READOUT;
            end else begin
               state_nxt_s = ST_ACCUM;
            end
         end
         ST_READOUT: begin
            if (frame_start) begin
               state_nxt_s = ST_CLEAR;
            end else if (xfer_s && col_last_r) begin
               state_nxt_s = ST_IDLE;
            end else begin
               state_nxt_s = ST_READOUT;
            end
         end
         default: begin
            state_nxt_s = ST_CLEAR;
         end
      endcase
   end

   // remember a frame_start that must begin accumulation once clearing ends
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         start_pend_r <= 1'b0;
      end else if (abort_s) begin
         start_pend_r <= 1'b1;
      end else if (state_r == ST_CLEAR) begin
         if (clr_done_s) begin
            start_pend_r <= 1'b0;
         end else if (frame_start) begin
            start_pend_r <= 1'b1;
         end
      end
   end

   // clear sweep pointer, parked at 0 outside CLEAR
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         clr_ptr_r <= '0;
      end else if ((state_r == ST_CLEAR) && !clr_done_s) begin
         clr_ptr_r <= clr_ptr_r + 1'b1;
      end else begin
         clr_ptr_r <= '0;
      end
   end

   // pixel position within the frame
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         x_r <= '0;
         y_r <= '0;
      end else if ((state_r != ST_ACCUM) || frame_start) begin
         x_r <= '0;
         y_r <= '0;
      end else if (accept_pix_s) begin
         if (pix_last) begin
            x_r <= '0;
            y_r <= y_r + 1'b1;
         end else if (x_in_range_s) begin
            x_r <= x_r + 1'b1;
         end
      end
   end

   // single memory write port: clear sweep, accumulate, or read-and-clear
   always_comb begin
      mem_we_s    = 1'b0;
      mem_addr_s  = '0;
      mem_wdata_s = '0;
      case (state_r)
         ST_CLEAR: begin
            mem_we_s   = 1'b1;
            mem_addr_s = clr_ptr_r;
         end
         ST_ACCUM: begin
            if (accept_pix_s && x_in_range_s && pix_white_s) begin
               mem_we_s    = 1'b1;
               mem_addr_s  = x_r[X_W-1:0];
               mem_wdata_s = mem_r[x_r[X_W-1:0]] + 1'b1;
            end else begin
               mem_we_s = 1'b0;
            end
         end
         ST_READOUT: begin
            if (xfer_s) begin
               mem_we_s   = 1'b1;
               mem_addr_s = col_idx_r;
            end else begin
               mem_we_s = 1'b0;
            end
         end
         default: begin
            mem_we_s = 1'b0;
         end
      endcase
   end

   // projection memory, zeroed by the CLEAR sweep rather than by reset
   always_ff @(posedge clk) begin
      if (mem_we_s) begin
         mem_r[mem_addr_s] <= mem_wdata_s;
      end
   end

   // readout stream: load column 0 on entry, advance on each handshake
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         col_valid_r  <= 1'b0;
         col_last_r   <= 1'b0;
         col_idx_r    <= '0;
         col_count_r  <= '0;
         frame_done_r <= 1'b0;
      end else if (abort_s) begin
         col_valid_r  <= 1'b0;
         col_last_r   <= 1'b0;
         frame_done_r <= 1'b0;
      end else if (state_r == ST_READOUT) begin
         if (!col_valid_r) begin
            col_valid_r  <= 1'b1;
            col_idx_r    <= '0;
            col_count_r  <= mem_r[0];
            col_last_r   <= (X_LAST_C == '0);
            frame_done_r <= 1'b0;
         end else if (xfer_s) begin
            if (col_last_r) begin
               col_valid_r  <= 1'b0;
               col_last_r   <= 1'b0;
               frame_done_r <= 1'b1;
            end else begin
               col_idx_r    <= nxt_idx_s;
               col_count_r  <= mem_r[nxt_idx_s];
               col_last_r   <= (nxt_idx_s == X_LAST_C);
               frame_done_r <= 1'b0;
            end
         end else begin
            frame_done_r <= 1'b0;
         end
      end else begin
         frame_done_r <= 1'b0;
      end
   end

   // sticky overrun; frame_start clears it and never sets it
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         overrun_r <= 1'b0;
      end else if (frame_start) begin
         overrun_r <= 1'b0;
      end else if (pix_valid && (state_r != ST_ACCUM)) begin
         overrun_r <= 1'b1;
      end
   end

   // busy follows the state being entered so it lines up with the state
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         busy_r <= 1'b0;
      end else begin
         busy_r <= (state_nxt_s != ST_IDLE);
      end
   end

   assign col_valid  = col_valid_r;
   assign col_idx    = col_idx_r;
   assign col_count  = col_count_r;
   assign col_last   = col_last_r;
   assign busy       = busy_r;
   assign frame_done = frame_done_r;
   assign overrun    = overrun_r;

`ifdef ROW_PROJ_EN
   logic [X_W:0] row_acc_r;
   logic [X_W:0] row_count_r;
   logic         row_valid_r;
   logic [X_W:0] row_add_s;

   assign row_add_s = {{X_W{1'b0}}, (x_in_range_s && pix_white_s)};

   // per-row white count, published one cycle after the row's last pixel
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         row_acc_r   <= '0;
         row_count_r <= '0;
         row_valid_r <= 1'b0;
      end else if ((state_r != ST_ACCUM) || frame_start) begin
         row_acc_r   <= '0;
         row_valid_r <= 1'b0;
      end else if (accept_pix_s) begin
         if (pix_last) begin
            row_count_r <= row_acc_r + row_add_s;
            row_acc_r   <= '0;
            row_valid_r <= 1'b1;
         end else begin
            row_acc_r   <= row_acc_r + row_add_s;
            row_valid_r <= 1'b0;
         end
      end else begin
         row_valid_r <= 1'b0;
      end
   end

   assign row_valid = row_valid_r;
   assign row_count = row_count_r;
`endif

endmodule

// File: tb/tb_column_projection.sv
// Directed bench for column_projection with a 4x3 image.
// Frame vectors live in a table; abort, short/long rows and overrun are
// exercised by hand-written sequences.
module tb_column_projection;

   localparam int IMG_W = 4;
   localparam int IMG_H = 3;
   localparam int X_W   = 2;
   localparam int CNT_W = 2;

   logic             clk = 1'b0;
   logic             rst;
   logic             frame_start;
   logic             pix_valid;
   logic             pix_last;
   logic [11:0]      pixel_binary;
   logic             col_valid;
   logic             col_ready;
   logic [X_W-1:0]   col_idx;
   logic [CNT_W-1:0] col_count;
   logic             col_last;
   logic             busy;
   logic             frame_done;
   logic             overrun;
`ifdef ROW_PROJ_EN
   logic             row_valid;
   logic [X_W:0]     row_count;
`endif

   int n_cmp = 0;
   int n_err = 0;

   typedef struct packed {
      logic [11:0] rows;    // row r, column c white when rows[r*4+c]
      logic        toggle;  // col_ready alternates 1/0 during readout
      logic [7:0]  exp;     // expected count of column c at exp[c*2 +: 2]
   } vec_t;

   vec_t vecs [6];

   column_projection #(
      .IMG_W(IMG_W), .IMG_H(IMG_H), .X_W(X_W), .CNT_W(CNT_W)
   ) dut (
      .clk(clk), .rst(rst), .frame_start(frame_start), .pix_valid(pix_valid),
      .pix_last(pix_last), .pixel_binary(pixel_binary), .col_valid(col_valid),
      .col_ready(col_ready), .col_idx(col_idx), .col_count(col_count),
      .col_last(col_last), .busy(busy), .frame_done(frame_done), .overrun(overrun)
`ifdef ROW_PROJ_EN
      , .row_valid(row_valid), .row_count(row_count)
`endif
   );

   always #5 clk = ~clk;

   initial begin
      #200000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
      n_cmp++;
      if (act !== exp) begin
         n_err++;
         $display("FAIL %s: got %0h, expected %0h", nm, act, exp);
      end
   endtask

   task automatic idle(input int n);
      repeat (n) begin
         @(posedge clk); #1;
         frame_start = 1'b0; pix_valid = 1'b0; pix_last = 1'b0; pixel_binary = 12'h000;
      end
   endtask

   task automatic start_frame();
      @(posedge clk); #1;
      frame_start = 1'b1; pix_valid = 1'b0; pix_last = 1'b0;
   endtask

   task automatic send_row(input logic [5:0] mask, input int len,
                           input logic [11:0] black, input bit do_last);
      for (int i = 0; i < len; i++) begin
         @(posedge clk); #1;
         frame_start  = 1'b0;
         pix_valid    = 1'b1;
         pix_last     = do_last && (i == len - 1);
         pixel_binary = mask[i] ? 12'hFFF : black;
      end
   endtask

   task automatic send_frame(input logic [11:0] rows);
      start_frame();
      for (int r = 0; r < IMG_H; r++) begin
         send_row({2'b00, rows[r*4 +: 4]}, 4, 12'h000, 1'b1);
      end
   endtask

   task automatic readout(input logic [7:0] exp, input bit toggle);
      int ei;
      int cyc;
      ei  = 0;
      cyc = 0;
      while (ei < IMG_W && cyc < 40) begin
         @(posedge clk); #1;
         frame_start = 1'b0; pix_valid = 1'b0; pix_last = 1'b0;
         col_ready = toggle ? (cyc % 2 == 0) : 1'b1;
         cyc++;
         @(negedge clk);
         if (col_valid) begin
            chk("col_idx", 32'(col_idx), 32'(ei));
            chk("col_count", 32'(col_count), 32'(exp[ei*2 +: 2]));
            if (col_ready) begin
               chk("col_last", 32'(col_last), 32'(ei == IMG_W - 1));
               chk("frame_done_early", 32'(frame_done), 32'd0);
               ei++;
            end
         end
      end
      if (ei < IMG_W) begin
         chk("readout_timeout", 32'(ei), 32'(IMG_W));
      end
      @(posedge clk); #1;
      col_ready = 1'b0;
      @(negedge clk);
      chk("frame_done_pulse", 32'(frame_done), 32'd1);
      chk("col_valid_drop", 32'(col_valid), 32'd0);
      @(posedge clk); #1;
      @(negedge clk);
      chk("frame_done_single", 32'(frame_done), 32'd0);
      chk("busy_after_frame", 32'(busy), 32'd0);
   endtask

   initial begin
      bit found;

      vecs[0] = '{12'h000, 1'b0, 8'h00};   // empty frame
      vecs[1] = '{12'h555, 1'b0, 8'h33};   // FFF,000,FFF,000 rows -> 3,0,3,0
      vecs[2] = '{12'h555, 1'b1, 8'h33};   // same, stalled readout
      vecs[3] = '{12'hA0F, 1'b0, 8'h99};   // 1111,0000,0101(c1,c3) -> 1,2,1,2
      vecs[4] = '{12'h696, 1'b0, 8'h69};   // checker rows -> 1,2,2,1
      vecs[5] = '{12'hFFF, 1'b1, 8'hFF};   // all white, stalled -> 3,3,3,3

      rst = 1'b1; frame_start = 1'b0; pix_valid = 1'b0; pix_last = 1'b0;
      pixel_binary = 12'h000; col_ready = 1'b0;

      // reset values
      repeat (2) @(posedge clk);
      @(negedge clk);
      chk("rst_col_valid", 32'(col_valid), 32'd0);
      chk("rst_busy", 32'(busy), 32'd0);
      chk("rst_frame_done", 32'(frame_done), 32'd0);
      chk("rst_overrun", 32'(overrun), 32'd0);
      chk("rst_col_idx", 32'(col_idx), 32'd0);
      chk("rst_col_count", 32'(col_count), 32'd0);
      chk("rst_col_last", 32'(col_last), 32'd0);

      // clear sweep lasts IMG_W cycles after reset release
      @(posedge clk); #1;
      rst = 1'b0;
      repeat (3) @(posedge clk);
      @(negedge clk);
      chk("busy_in_clear", 32'(busy), 32'd1);
      @(posedge clk);
      @(negedge clk);
      chk("busy_after_clear", 32'(busy), 32'd0);

      // table-driven frames
      for (int v = 0; v < 6; v++) begin
         send_frame(vecs[v].rows);
         readout(vecs[v].exp, vecs[v].toggle);
      end

      // over-long row saturates x, short row is legal, bit 11 alone decides
      start_frame();
      send_row(6'b111111, 6, 12'h000, 1'b1);
      send_row(6'b000011, 2, 12'h000, 1'b1);
      send_row(6'b000000, 4, 12'h7FF, 1'b1);
      readout(8'h5A, 1'b0);
      chk("overrun_long_row", 32'(overrun), 32'd0);

      // abort mid-row 1, then a full white frame after the clear sweep
      start_frame();
      send_row(6'b001111, 4, 12'h000, 1'b1);
      send_row(6'b000011, 2, 12'h000, 1'b0);
      start_frame();
      @(negedge clk);
      @(posedge clk); #1;
      frame_start = 1'b0; pix_valid = 1'b0;
      @(negedge clk);
      chk("abort_accum_busy", 32'(busy), 32'd1);
      idle(6);
      for (int r = 0; r < IMG_H; r++) send_row(6'b001111, 4, 12'h000, 1'b1);
      readout(8'hFF, 1'b0);
      chk("overrun_after_abort", 32'(overrun), 32'd0);

      // abort during readout after one column transferred
      send_frame(12'hFFF);
      found = 1'b0;
      for (int k = 0; k < 10 && !found; k++) begin
         @(posedge clk); #1;
         pix_valid = 1'b0; pix_last = 1'b0; col_ready = 1'b1;
         @(negedge clk);
         if (col_valid) found = 1'b1;
      end
      chk("abort_rd_found", 32'(found), 32'd1);
      chk("abort_rd_idx0", 32'(col_idx), 32'd0);
      chk("abort_rd_cnt0", 32'(col_count), 32'd3);
      @(posedge clk); #1;
      frame_start = 1'b1; col_ready = 1'b0;
      @(negedge clk);
      chk("abort_rd_idx1", 32'(col_idx), 32'd1);
      @(posedge clk); #1;
      frame_start = 1'b0;
      @(negedge clk);
      chk("abort_rd_valid_low", 32'(col_valid), 32'd0);
      chk("abort_rd_busy", 32'(busy), 32'd1);
      chk("abort_rd_no_done", 32'(frame_done), 32'd0);
      idle(5);
      for (int r = 0; r < IMG_H; r++) send_row(6'b000000, 4, 12'h000, 1'b1);
      readout(8'h00, 1'b0);
      chk("overrun_after_rd_abort", 32'(overrun), 32'd0);

      // pixel in IDLE sets overrun; next frame_start clears it
      @(posedge clk); #1;
      pix_valid = 1'b1; pix_last = 1'b1; pixel_binary = 12'hFFF;
      @(posedge clk); #1;
      pix_valid = 1'b0; pix_last = 1'b0;
      @(negedge clk);
      chk("overrun_set", 32'(overrun), 32'd1);
      chk("overrun_idle_busy", 32'(busy), 32'd0);
      start_frame();
      @(posedge clk); #1;
      frame_start = 1'b0;
      @(negedge clk);
      chk("overrun_cleared", 32'(overrun), 32'd0);
      chk("overrun_accum_busy", 32'(busy), 32'd1);
      for (int r = 0; r < IMG_H; r++) send_row(6'b001111, 4, 12'h000, 1'b1);
      readout(8'hFF, 1'b0);

`ifdef ROW_PROJ_EN
      // row projection: each row FFF,FFF,000,FFF
      start_frame();
      for (int r = 0; r < IMG_H; r++) begin
         send_row(6'b001011, 4, 12'h000, 1'b1);
         @(posedge clk); #1;
         pix_valid = 1'b0; pix_last = 1'b0;
         @(negedge clk);
         chk("row_valid", 32'(row_valid), 32'd1);
         chk("row_count", 32'(row_count), 32'd3);
         if (r < IMG_H - 1) begin
            @(posedge clk); #1;
            @(negedge clk);
            chk("row_valid_pulse", 32'(row_valid), 32'd0);
         end
      end
      readout(8'hCF, 1'b0);
`endif

      $display("== %0d vectors applied, %0d miscompares ==", n_cmp, n_err);
      $finish;
   end

endmodule
